// File: rtl/cp0_ctrl.sv
// MIPS coprocessor-0: Count/Compare timer, Status, Cause, EPC, IRQ and ERET.
// Define CP0_BADVADDR_EN to add the BadVAddr register and exc_badvaddr port.
module cp0_ctrl #(
    parameter int          NUM_IRQ    = 5,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         rd_cs,
    input  logic [2:0]         rd_sel,
    output logic [31:0]        rd_data,
    input  logic               wr_en,
    input  logic [4:0]         wr_cs,
    input  logic [2:0]         wr_sel,
    input  logic [31:0]        wr_data,
    input  logic               exc_req,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        exc_pc,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0]        exc_badvaddr,
`endif
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               int_req,
    output logic [31:0]        epc_out,
    output logic               exl_out
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0]      psc;
    logic [31:0]        count;
    logic [31:0]        compare;
    logic [31:0]        epc;
    logic [7:0]         im;
    logic               exl;
    logic               ie;
    logic               ip7;
    logic [NUM_IRQ-1:0] ip_hw;
    logic [1:0]         ip_sw;
    logic [4:0]         exccode;

    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        psc_wrap, count_upd;
    logic [31:0] count_nxt;
    logic [4:0]  hw5;
    logic [31:0] status_v, cause_v;

    assign wr_count   = wr_en && wr_sel == 3'd0 && wr_cs == 5'd9;
    assign wr_compare = wr_en && wr_sel == 3'd0 && wr_cs == 5'd11;
    assign wr_status  = wr_en && wr_sel == 3'd0 && wr_cs == 5'd12;
    assign wr_cause   = wr_en && wr_sel == 3'd0 && wr_cs == 5'd13;
    assign wr_epc     = wr_en && wr_sel == 3'd0 && wr_cs == 5'd14;

    assign psc_wrap  = (psc == PW'(COUNT_DIV - 1));
    assign count_upd = wr_count | psc_wrap;
    assign count_nxt = wr_count ? wr_data
                     : psc_wrap ? count + 32'd1
                     : count;

    always_comb begin
        hw5 = '0;
        hw5[NUM_IRQ-1:0] = ip_hw;
    end

    assign status_v = {16'h0, im, 6'h0, exl, ie};
    assign cause_v  = {16'h0, ip7, hw5, ip_sw, 1'b0, exccode, 2'b00};

    assign int_req = ie & ~exl & |(cause_v[15:8] & im);
    assign epc_out = epc;
    assign exl_out = exl;

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            badvaddr <= '0;
        else if (exc_req && (exc_code == 5'd4 || exc_code == 5'd5))
            badvaddr <= exc_badvaddr;
    end
`endif

    always_comb begin
        rd_data = '0;
        if (rd_sel == 3'd0) begin
            case (rd_cs)
`ifdef CP0_BADVADDR_EN
                5'd8:    rd_data = badvaddr;
`endif
                5'd9:    rd_data = count;
                5'd11:   rd_data = compare;
                5'd12:   rd_data = status_v;
                5'd13:   rd_data = cause_v;
                5'd14:   rd_data = epc;
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc <= '0;
            count <= '0;
            compare <= '0;
        end else begin
            psc <= count_upd ? '0 : psc + PW'(1);
            count <= count_nxt;
            if (wr_compare)
                compare <= wr_data;
        end
    end

    // Match is only taken when Count actually changes, so a stalled
    // Count sitting on Compare does not re-raise IP7 after a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip7 <= 1'b0;
            ip_hw <= '0;
            ip_sw <= '0;
            exccode <= '0;
        end else begin
            if (wr_compare)
                ip7 <= 1'b0;
            else if (count_upd && count_nxt == compare)
                ip7 <= 1'b1;
            ip_hw <= irq_in;
            if (wr_cause)
                ip_sw <= wr_data[9:8];
            if (exc_req)
                exccode <= exc_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im <= STATUS_RST[15:8];
            exl <= STATUS_RST[1];
            ie <= STATUS_RST[0];
            epc <= '0;
        end else begin
            if (wr_status) begin
                im <= wr_data[15:8];
                ie <= wr_data[0];
            end
            if (exc_req)
                exl <= 1'b1;
            else if (eret)
                exl <= 1'b0;
            else if (wr_status)
                exl <= wr_data[1];
            if (exc_req && !exl)
                epc <= exc_pc;
            else if (wr_epc)
                epc <= wr_data;
        end
    end

endmodule
